// File: rtl/param_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// param_universal_shift_reg
//
// Parameterised universal shift register. It accepts single-step commands
// (hold, shift, rotate, load, arithmetic shift) and multi-cycle burst shifts.
// Commands are taken with a valid/ready handshake.
//
// Ports:
//   clk              - single clock; all state updates on its rising edge
//   rst_n            - synchronous active-low reset
//   in_valid         - a command is present
//   in_ready         - a command is accepted this cycle (high when idle)
//   op[2:0]          - command opcode
//   d[WIDTH-1:0]     - parallel load data
//   amt[CNT_W-1:0]   - burst shift count (saturated to WIDTH)
//   cmd_dir          - burst direction: 0 = right, 1 = left
//   serial_in_left   - fill bit for left shifts
//   serial_in_right  - fill bit for right shifts
//   q[WIDTH-1:0]     - register contents
//   serial_out_left  - q[WIDTH-1]
//   serial_out_right - q[0]
//   busy             - high while a burst executes
//   done             - one-cycle pulse when a burst completes
// -----------------------------------------------------------------------------
module param_universal_shift_reg #(
  parameter int                WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  localparam int               CNT_W     = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic [CNT_W-1:0] amt,
  input  logic             cmd_dir,
  input  logic             serial_in_left,
  input  logic             serial_in_right,
  output logic [WIDTH-1:0] q,
  output logic             serial_out_left,
  output logic             serial_out_right,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic             dir_reg,   dir_next;
  logic [WIDTH-1:0] q_reg,     q_next;
  logic             done_reg,  done_next;

  // Candidate next values for every single-bit move, built per bit so the
  // edge bits (fill / wrap / sign) are explicit.
  logic [WIDTH-1:0] shr_vec, shl_vec, ror_vec, rol_vec, asr_vec;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bits
      if (gi == WIDTH - 1) begin : g_msb
        assign shr_vec[gi] = serial_in_right;
        assign ror_vec[gi] = q_reg[0];
        assign asr_vec[gi] = q_reg[WIDTH-1];
      end else begin : g_not_msb
        assign shr_vec[gi] = q_reg[gi+1];
        assign ror_vec[gi] = q_reg[gi+1];
        assign asr_vec[gi] = q_reg[gi+1];
      end
      if (gi == 0) begin : g_lsb
        assign shl_vec[gi] = serial_in_left;
        assign rol_vec[gi] = q_reg[WIDTH-1];
      end else begin : g_not_lsb
        assign shl_vec[gi] = q_reg[gi-1];
        assign rol_vec[gi] = q_reg[gi-1];
      end
    end
  endgenerate

  logic accept;
  assign accept = in_valid && (state_reg == IDLE);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    q_next     = q_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          case (op)
            3'b000: q_next = q_reg;
            3'b001: q_next = shr_vec;
            3'b010: q_next = shl_vec;
            3'b011: q_next = d;
            3'b100: q_next = ror_vec;
            3'b101: q_next = rol_vec;
            3'b110: q_next = asr_vec;
            default: begin
              // Burst: no shift on the accepting edge. A zero count
              // completes immediately without leaving IDLE.
              if (amt == '0) begin
                done_next = 1'b1;
              end else begin
                cnt_next   = (amt > CNT_MAX) ? CNT_MAX : amt;
                dir_next   = cmd_dir;
                state_next = BURST;
              end
            end
          endcase
        end
      end
      BURST: begin
        q_next   = dir_reg ? shl_vec : shr_vec;
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dir_reg   <= 1'b0;
      q_reg     <= RESET_VAL;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= dir_next;
      q_reg     <= q_next;
      done_reg  <= done_next;
    end
  end

  assign in_ready         = (state_reg == IDLE);
  assign busy             = (state_reg == BURST);
  assign done             = done_reg;
  assign q                = q_reg;
  assign serial_out_left  = q_reg[WIDTH-1];
  assign serial_out_right = q_reg[0];

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_param_universal_shift_reg
//
// Directed scenarios followed by randomized traffic. A reference model
// updates on every rising edge and queues the expected outputs; a monitor
// pops and compares on the falling edge. Directed scenarios add a few
// constant checks at key points.
// -----------------------------------------------------------------------------
module tb_param_universal_shift_reg;

  localparam int W   = 8;
  localparam int CW  = $clog2(W + 1);
  localparam logic [W-1:0] RV  = 8'h00;
  localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready;
  logic [2:0]    op;
  logic [W-1:0]  d, q;
  logic [CW-1:0] amt;
  logic          cmd_dir, serial_in_left, serial_in_right;
  logic          serial_out_left, serial_out_right, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] q;
    logic         rdy;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];

  param_universal_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .d(d), .amt(amt), .cmd_dir(cmd_dir),
    .serial_in_left(serial_in_left), .serial_in_right(serial_in_right),
    .q(q), .serial_out_left(serial_out_left),
    .serial_out_right(serial_out_right), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: remaining-shift count stands for the whole burst.
  logic [W-1:0] m_q;
  int           m_rem = 0;
  logic         m_dir;
  logic         m_done;

  always @(posedge clk) begin
    int   n;
    logic dn;
    if (!rst_n) begin
      m_q = RV; m_rem = 0; m_done = 1'b0;
    end else begin
      dn = 1'b0;
      if (m_rem > 0) begin
        if (m_dir) m_q = (m_q << 1) | W'(serial_in_left);
        else       m_q = (m_q >> 1) | (serial_in_right ? MSB : '0);
        m_rem = m_rem - 1;
        if (m_rem == 0) dn = 1'b1;
      end else if (in_valid) begin
        case (op)
          3'd1: m_q = (m_q >> 1) | (serial_in_right ? MSB : '0);
          3'd2: m_q = (m_q << 1) | W'(serial_in_left);
          3'd3: m_q = d;
          3'd4: m_q = (m_q >> 1) | (m_q[0] ? MSB : '0);
          3'd5: m_q = (m_q << 1) | W'(m_q[W-1]);
          3'd6: m_q = (m_q >> 1) | (m_q & MSB);
          3'd7: begin
            n = (int'(amt) > W) ? W : int'(amt);
            if (n == 0) dn = 1'b1;
            else begin m_rem = n; m_dir = cmd_dir; end
          end
          default: ;
        endcase
      end
      m_done = dn;
    end
    exp_q.push_back('{q: m_q, rdy: (m_rem == 0), busy: (m_rem > 0), done: m_done});
  end

  // Monitor: one line per observed cycle only on mismatch.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (q !== e.q || in_ready !== e.rdy || busy !== e.busy || done !== e.done ||
          serial_out_left !== e.q[W-1] || serial_out_right !== e.q[0]) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got q=%h rdy=%b busy=%b done=%b sol=%b sor=%b, expected q=%h rdy=%b busy=%b done=%b",
                 $time, q, in_ready, busy, done, serial_out_left, serial_out_right,
                 e.q, e.rdy, e.busy, e.done);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Present a command for exactly one edge, then drop in_valid.
  task automatic cmd(input logic [2:0] o, input logic [W-1:0] dd, input logic [CW-1:0] a,
                     input logic dir, input logic sil, input logic sir);
    op = o; d = dd; amt = a; cmd_dir = dir;
    serial_in_left = sil; serial_in_right = sir; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; d = '0; amt = '0;
    cmd_dir = 1'b0; serial_in_left = 1'b0; serial_in_right = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_q", 32'(q), 32'(RV));
    chk("reset_ready", 32'(in_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    cmd(3'd3, 8'hA5, '0, 0, 0, 0);
    chk("load_a5", 32'(q), 32'hA5);

    cmd(3'd3, 8'h81, '0, 0, 0, 0); cmd(3'd4, '0, '0, 0, 0, 0);
    chk("ror_81", 32'(q), 32'hC0);
    cmd(3'd3, 8'h81, '0, 0, 0, 0); cmd(3'd5, '0, '0, 0, 0, 0);
    chk("rol_81", 32'(q), 32'h03);
    cmd(3'd3, 8'h81, '0, 0, 0, 0); cmd(3'd6, '0, '0, 0, 0, 0);
    chk("asr_81", 32'(q), 32'hC0);
    cmd(3'd3, 8'h81, '0, 0, 0, 0); cmd(3'd1, '0, '0, 0, 0, 0);
    chk("shr_81", 32'(q), 32'h40);

    // Burst left by 3.
    cmd(3'd3, 8'h01, '0, 0, 0, 0);
    cmd(3'd7, '0, CW'(3), 1, 0, 0);
    chk("burst_busy", 32'(busy), 32'd1);
    chk("burst_not_ready", 32'(in_ready), 32'd0);
    idle(2);
    chk("burst_still_busy", 32'(busy), 32'd1);
    idle(1);
    chk("burst_q", 32'(q), 32'h08);
    chk("burst_done", 32'(done), 32'd1);
    chk("burst_ready", 32'(in_ready), 32'd1);
    idle(1);
    chk("burst_done_once", 32'(done), 32'd0);

    // amt = 0.
    cmd(3'd3, 8'h3C, '0, 0, 0, 0);
    cmd(3'd7, '0, '0, 0, 0, 0);
    chk("amt0_done", 32'(done), 32'd1);
    chk("amt0_busy", 32'(busy), 32'd0);
    chk("amt0_q", 32'(q), 32'h3C);

    // amt saturates to WIDTH.
    cmd(3'd3, 8'h00, '0, 0, 0, 0);
    cmd(3'd7, '0, CW'(15), 0, 0, 1);
    idle(W);
    chk("sat_q", 32'(q), 32'hFF);
    chk("sat_done", 32'(done), 32'd1);

    // Reset in the second cycle of a 5-shift burst.
    cmd(3'd7, '0, CW'(5), 1, 1, 0);
    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_q", 32'(q), 32'(RV));
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd1);
    cmd(3'd3, 8'h5A, '0, 0, 0, 0);
    chk("after_abort_load", 32'(q), 32'h5A);

    // Back-to-back bursts with in_valid held high.
    op = 3'd7; amt = CW'(2); cmd_dir = 1'b0; serial_in_right = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_first_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    chk("b2b_first_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("b2b_second_busy", 32'(busy), 32'd1);
    op = 3'd3; d = 8'hFF;          // ignored while busy
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_second_q", 32'(q), 32'h05);
    chk("b2b_second_done", 32'(done), 32'd1);

    // Randomized traffic, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n           = ($urandom_range(0, 99) != 0);
      in_valid        = $urandom_range(0, 1);
      op              = 3'($urandom_range(0, 7));
      d               = W'($urandom);
      amt             = CW'($urandom_range(0, 15));
      cmd_dir         = $urandom_range(0, 1);
      serial_in_left  = $urandom_range(0, 1);
      serial_in_right = $urandom_range(0, 1);
      @(negedge clk);
    end
    rst_n = 1'b1;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
